// File: rtl/sym_round_ctrl.sv
// Round sequencer for the symbol-counter game.
// Paces symbol spawns from the level-dependent period, keeps score and lives,
// and hands off to the level controller after enough hits in a round.
module sym_round_ctrl #(
    parameter int HITS_PER_LEVEL = 10,
    parameter int START_LIVES    = 3,
    parameter int MAX_LEVEL      = 15,
    parameter int MIN_PERIOD     = 1000,
    parameter int MAX_PERIOD     = 100000000,
    parameter int ACK_TIMEOUT    = 4
) (
    input  logic        Clk100M,
    input  logic        Rst,
    input  logic        start,
    input  logic        symHit,
    input  logic        symMiss,
    input  logic        newLevel,
    input  logic [3:0]  curLevel,
    input  logic [31:0] symGenMax,
    output logic        spawnSym,
    output logic        incLevel,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic        gameOver,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        RUN       = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } roundState_t;

    // Counter widths only need to hold 0..N-1 because both counters wrap on their last value.
    localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [31:0]      MIN_P      = 32'(MIN_PERIOD);
    localparam logic [31:0]      MAX_P      = 32'(MAX_PERIOD);
    localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

    roundState_t      curState;
    logic [31:0]      periodCnt;
    logic [31:0]      period;
    logic [HIT_W-1:0] hitCnt;
    logic [ACK_W-1:0] ackCnt;

    logic [31:0] periodLast;
    logic        periodInRange;
    logic        levelBelowMax;
    logic        lastLife;

    assign state         = curState;
    assign periodLast    = period - 32'd1;
    assign periodInRange = (symGenMax >= MIN_P) && (symGenMax <= MAX_P);
    assign levelBelowMax = int'(curLevel) < MAX_LEVEL;
    assign lastLife      = symMiss && (lives == 3'd1);

    // Round state machine; every output is a register updated here.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            curState  <= IDLE;
            spawnSym  <= 1'b0;
            incLevel  <= 1'b0;
            score     <= 16'd0;
            lives     <= LIVES_INIT;
            gameOver  <= 1'b0;
            periodCnt <= 32'd0;
            period    <= MIN_P;
            hitCnt    <= '0;
            ackCnt    <= '0;
        end else begin
            spawnSym <= 1'b0;
            incLevel <= 1'b0;
            unique case (curState)
                IDLE: begin
                    if (start) curState <= ARM;
                end
                ARM: begin
                    period    <= periodInRange ? symGenMax : MIN_P;
                    periodCnt <= 32'd0;
                    curState  <= RUN;
                end
                RUN, LEVEL_UP: begin
                    if (curState == RUN) begin
                        if (periodCnt == periodLast) begin
                            periodCnt <= 32'd0;
                            spawnSym  <= 1'b1;
                        end else begin
                            periodCnt <= periodCnt + 32'd1;
                        end
                    end
                    if (symHit && (score != 16'hFFFF)) score <= score + 16'd1;
                    if (lastLife) begin
                        lives    <= 3'd0;
                        gameOver <= 1'b1;
                        spawnSym <= 1'b0;
                        hitCnt   <= '0;
                        curState <= GAME_OVER;
                    end else begin
                        if (symMiss) lives <= lives - 3'd1;
                        if (curState == RUN) begin
                            if (symHit) begin
                                if (hitCnt == HIT_LAST) begin
                                    hitCnt <= '0;
                                    if (levelBelowMax) begin
                                        incLevel <= 1'b1;
                                        ackCnt   <= '0;
                                        curState <= LEVEL_UP;
                                    end
                                end else begin
                                    hitCnt <= hitCnt + HIT_W'(1);
                                end
                            end
                        end else if (newLevel || (ackCnt == ACK_LAST)) begin
                            curState <= ARM;
                        end else begin
                            ackCnt <= ackCnt + ACK_W'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        score    <= 16'd0;
                        hitCnt   <= '0;
                        lives    <= LIVES_INIT;
                        gameOver <= 1'b0;
                        curState <= ARM;
                    end
                end
                default: curState <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_round_ctrl.sv
// Testbench for sym_round_ctrl: directed round scenarios followed by random play,
// every cycle compared against a behavioural model of the round rules.
module tb_sym_round_ctrl;

    localparam int HITS  = 3;
    localparam int LIVES = 3;
    localparam int MAXL  = 15;
    localparam int MINP  = 4;
    localparam int MAXP  = 64;
    localparam int ACKT  = 4;

    logic        Clk100M = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic        symHit = 1'b0;
    logic        symMiss = 1'b0;
    logic        newLevel = 1'b0;
    logic [3:0]  curLevel = 4'd1;
    logic [31:0] symGenMax = 32'd10;
    logic        spawnSym;
    logic        incLevel;
    logic [15:0] score;
    logic [2:0]  lives;
    logic        gameOver;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int spawnCount;

    // Behavioural model of the round: ages in cycles instead of wrapping counters.
    int          mState;
    int          mScore;
    int          mLives;
    int          mHits;
    int          mLvlAge;
    longint      mRunAge;
    logic [31:0] mP;
    bit          mSpawn;
    bit          mInc;

    sym_round_ctrl #(
        .HITS_PER_LEVEL(HITS),
        .START_LIVES(LIVES),
        .MAX_LEVEL(MAXL),
        .MIN_PERIOD(MINP),
        .MAX_PERIOD(MAXP),
        .ACK_TIMEOUT(ACKT)
    ) dut (
        .Clk100M(Clk100M),
        .Rst(Rst),
        .start(start),
        .symHit(symHit),
        .symMiss(symMiss),
        .newLevel(newLevel),
        .curLevel(curLevel),
        .symGenMax(symGenMax),
        .spawnSym(spawnSym),
        .incLevel(incLevel),
        .score(score),
        .lives(lives),
        .gameOver(gameOver),
        .state(state)
    );

    // 100 MHz clock.
    always #5 Clk100M = ~Clk100M;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit overNow;
        mSpawn  = 1'b0;
        mInc    = 1'b0;
        overNow = 1'b0;
        if (Rst) begin
            mState = 0; mScore = 0; mLives = LIVES; mHits = 0;
            mP = MINP; mRunAge = 0; mLvlAge = 0;
        end else begin
            case (mState)
                0: if (start) mState = 1;
                1: begin
                    mP = (symGenMax >= 32'(MINP) && symGenMax <= 32'(MAXP)) ? symGenMax : 32'(MINP);
                    mRunAge = 0;
                    mState = 2;
                end
                2, 3: begin
                    if (mState == 2) begin
                        mRunAge++;
                        mSpawn = (mRunAge % longint'(mP)) == 0;
                    end else begin
                        mLvlAge++;
                    end
                    if (symHit && mScore < 65535) mScore++;
                    if (symMiss) begin
                        if (mLives == 1) begin
                            mLives = 0;
                            overNow = 1'b1;
                        end else begin
                            mLives--;
                        end
                    end
                    if (overNow) begin
                        mState = 4; mHits = 0; mSpawn = 1'b0;
                    end else if (mState == 2) begin
                        if (symHit) begin
                            mHits++;
                            if (mHits == HITS) begin
                                mHits = 0;
                                if (int'(curLevel) < MAXL) begin
                                    mInc = 1'b1; mState = 3; mLvlAge = 0;
                                end
                            end
                        end
                    end else if (newLevel || mLvlAge == ACKT) begin
                        mState = 1;
                    end
                end
                4: if (start) begin
                    mScore = 0; mHits = 0; mLives = LIVES; mState = 1;
                end
                default: mState = 0;
            endcase
        end
    endtask

    task automatic checkOutput();
        checkVal("spawnSym", 32'(spawnSym), 32'(mSpawn));
        checkVal("incLevel", 32'(incLevel), 32'(mInc));
        checkVal("score", 32'(score), 32'(mScore));
        checkVal("lives", 32'(lives), 32'(mLives));
        checkVal("gameOver", 32'(gameOver), 32'(mState == 4));
        checkVal("state", 32'(state), 32'(mState));
    endtask

    task automatic applyStimulus(input bit iStart, input bit iHit, input bit iMiss, input bit iNew);
        start    = iStart;
        symHit   = iHit;
        symMiss  = iMiss;
        newLevel = iNew;
        modelStep();
        @(posedge Clk100M);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        Rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
    endtask

    initial begin
        // Reset state, hits/misses ignored in IDLE.
        doReset();
        checkVal("reset_state", 32'(state), 32'd0);
        checkVal("reset_lives", 32'(lives), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("idle_ignores_hit", 32'(score), 32'd0);

        // Spawn pacing with period 10, then reset mid-round.
        symGenMax = 32'd10;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("arm_state", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        spawnCount = 0;
        for (int i = 1; i <= 25; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (spawnSym) spawnCount++;
            if (i == 10) checkVal("first_spawn_p10", 32'(spawnSym), 32'd1);
        end
        checkVal("spawn_count_p10", 32'(spawnCount), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        doReset();
        checkVal("midrun_reset_state", 32'(state), 32'd0);
        checkVal("midrun_reset_score", 32'(score), 32'd0);

        // Level advance with acknowledge, new period 6.
        curLevel = 4'd1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("inc_on_third_hit", 32'(incLevel), 32'd1);
        checkVal("levelup_state", 32'(state), 32'd3);
        symGenMax = 32'd6;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("ack_to_arm", 32'(state), 32'd1);
        idle(20);
        checkVal("score_after_level", 32'(score), 32'd3);

        // Max level: no advance; wrapped period falls back to the floor.
        doReset();
        curLevel = 4'd15;
        symGenMax = 32'hFFFF_FFF0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("maxlevel_no_inc", 32'(incLevel), 32'd0);
        checkVal("maxlevel_stays_run", 32'(state), 32'd2);
        idle(12);

        // Period boundaries: exactly MAX, one above MAX, one below MIN.
        symGenMax = 32'(MAXP);
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(MAXP + 3);
        symGenMax = 32'(MAXP + 1);
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        symGenMax = 32'(MINP - 1);
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Acknowledge timeout, miss during LEVEL_UP.
        curLevel = 4'd2;
        symGenMax = 32'd8;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("levelup_miss_lives", 32'(lives), 32'd2);
        idle(2);
        checkVal("levelup_wait", 32'(state), 32'd3);
        idle(1);
        checkVal("timeout_to_arm", 32'(state), 32'd1);
        idle(3);

        // Game over with simultaneous hit and miss on the completing hit, then restart.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("gameover_state", 32'(state), 32'd4);
        checkVal("gameover_no_inc", 32'(incLevel), 32'd0);
        checkVal("gameover_score", 32'(score), 32'd3);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("restart_state", 32'(state), 32'd1);
        checkVal("restart_lives", 32'(lives), 32'd3);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            Rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) curLevel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                symGenMax = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 70));
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0);
        end
        Rst = 1'b0;

        // Score saturation.
        curLevel = 4'd15;
        symGenMax = 32'd20;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("score_saturated", 32'(score), 32'd65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sym_round_ctrl.md
Name: sym_round_ctrl

Overview:
Round sequencer for the symbol-counter game. It paces symbol spawns from the level-dependent period (symGenMax) and counts player hits and misses. It asks the level controller to advance (incLevel) after enough hits, then waits for the newLevel acknowledge and re-latches the new period. It also tracks lives and game-over.

Parameters:
HITS_PER_LEVEL, 10, correct hits required per level advance
START_LIVES, 3, lives at game start (1..7)
MAX_LEVEL, 15, curLevel at which incLevel is no longer issued
MIN_PERIOD, 1000, floor on the spawn period in clocks
MAX_PERIOD, 100000000, ceiling on the spawn period; larger values are treated as underflow
ACK_TIMEOUT, 4, clocks to wait in LEVEL_UP for newLevel

Ports:
Clk100M  in  1  system clock, 100 MHz
Rst  in  1  synchronous, active-high reset
start  in  1  start/restart request, level-sampled
symHit  in  1  one-cycle pulse, player matched the current symbol
symMiss  in  1  one-cycle pulse, player missed or mismatched
newLevel  in  1  level-advance acknowledge from the level controller
curLevel  in  4  current level from the level controller
symGenMax  in  32  spawn period in clocks from the level controller
spawnSym  out  1  one-cycle pulse, generate next symbol
incLevel  out  1  one-cycle pulse, request level advance
score  out  16  total hits, saturating
lives  out  3  remaining lives
gameOver  out  1  high while in GAME_OVER
state  out  3  IDLE=0, ARM=1, RUN=2, LEVEL_UP=3, GAME_OVER=4

Behaviour:
- Clock and reset: Clk100M is the only clock. Rst is synchronous, active-high. It overrides all other inputs, including mid-round.
- Reset values: state=IDLE, spawnSym=0, incLevel=0, score=0, lives=START_LIVES, gameOver=0. Internal period counter=0, hit counter=0, latched period=MIN_PERIOD.
- All outputs are registered.
- IDLE: start=1 -> ARM. Hits and misses are ignored.
- ARM (1 cycle): latch period P.
  - P=symGenMax if MIN_PERIOD<=symGenMax<=MAX_PERIOD.
  - Otherwise P=MIN_PERIOD. This covers underflow wrap of symGenMax and values below the floor.
  - Clear the period counter, then go to RUN.
- RUN:
  - Period counter increments every cycle.
  - When count==P-1: spawnSym=1 for one cycle and the counter returns to 0. The first spawn is P cycles after entering RUN, and spawns repeat every P cycles.
- symHit (RUN or LEVEL_UP): score+1, saturating at 65535. In RUN only, the hit counter also increments.
- Level-advance condition: in RUN, a hit that brings the hit counter to HITS_PER_LEVEL clears the counter to 0. Then:
  - curLevel<MAX_LEVEL: incLevel=1 for one cycle and go to LEVEL_UP.
  - curLevel>=MAX_LEVEL: no incLevel; stay in RUN.
- symMiss (RUN or LEVEL_UP): lives-1. If lives was 1, go to GAME_OVER and lives=0. The hit counter is unchanged.
- Simultaneous hit and miss in the same cycle:
  - score updates first.
  - The miss then applies.
  - If the miss reaches GAME_OVER, the level-advance condition is suppressed (no incLevel) and the hit counter is cleared.
- LEVEL_UP:
  - spawnSym is held at 0 and the period counter is frozen.
  - newLevel=1 -> ARM, which latches the updated symGenMax on the following cycle.
  - If newLevel has not arrived ACK_TIMEOUT cycles after entry -> ARM anyway, and the old period is re-latched from the current symGenMax.
  - incLevel is never reissued in LEVEL_UP.
- GAME_OVER:
  - gameOver=1; spawnSym=0 and incLevel=0.
  - Hits and misses are ignored.
  - start=1 -> clear score and the hit counter, set lives=START_LIVES, go to ARM. gameOver drops on that transition.
  - Resetting the level is out of scope for this block.
- start is ignored in ARM, RUN and LEVEL_UP.
- newLevel is ignored outside LEVEL_UP.
- Width rule: the period counter is 32-bit unsigned. Compare against P-1 with P>=MIN_PERIOD>=1, so no wrap is possible.

Test Plan:
1. Reset, then start with symGenMax=10 (MIN_PERIOD=4): first spawnSym 10 cycles after RUN entry, then every 10 cycles. Assert Rst mid-RUN -> next edge state=0, score=0, lives=3, no spawn.
2. HITS_PER_LEVEL=3, curLevel=1: three hits in RUN -> incLevel pulse on the 3rd hit's edge, state=3. newLevel pulse next cycle with symGenMax=6 -> ARM, then RUN with spawns every 6 cycles. score=3.
3. curLevel=15: three hits -> no incLevel, state stays 2, hit counter=0. symGenMax=0xFFFF_FFF0 on ARM -> P=MIN_PERIOD=4.
4. LEVEL_UP with no newLevel: state returns to ARM after 4 cycles. A miss during LEVEL_UP decrements lives 3->2.
5. Three misses -> lives 3,2,1,0, state=4, gameOver=1, no spawns. Hit and miss together on the final miss -> score+1, no incLevel. start -> lives=3, score=0, state=1.
6. Saturation: preload score to 65535 via hits, one more hit -> score stays 65535.
